// File: rtl/aes_uart_pkg.sv
// Shared types and helpers for the AES UART block/byte conversion paths.
package aes_uart_pkg;

  localparam int BLK_BYTES = 16;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
  } aes_blk_t;

  // Map a transmit-order position onto a byte lane of the 128-bit word.
  function automatic logic [3:0] pos_to_byte(input logic [3:0] pos, input logic lsbFirst);
    return lsbFirst ? pos : (4'(BLK_BYTES - 1) - pos);
  endfunction

endpackage

// File: rtl/aes_blk_serializer_keep_scan.sv
// Finds the next kept byte position at or after a start index, and whether
// it is the last kept position of the block.
module keep_scan (
  input  logic [15:0] keep_i,
  input  logic [3:0]  idx_i,
  output logic [3:0]  nxt_o,
  output logic        is_final_o
);

  // Lowest set position not below idx_i; scanning downward lets the lowest win.
  always_comb begin
    nxt_o = 4'd0;
    for (int p = 15; p >= 0; p--) begin
      if (keep_i[p] && (4'(p) >= idx_i)) begin
        nxt_o = 4'(p);
      end
    end
  end

  // The selected position is final when nothing above it is kept.
  always_comb begin
    is_final_o = 1'b1;
    for (int p = 0; p < 16; p++) begin
      if (keep_i[p] && (4'(p) > nxt_o)) begin
        is_final_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/aes_blk_serializer.sv
// Two-entry block buffer that drains 128-bit blocks as individual kept bytes
// towards the UART transmit selector. Blocks with no kept bytes are counted
// and discarded instead of being stored.
module aes_blk_serializer
  import aes_uart_pkg::*;
#(
  parameter int LSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         s_axis_tvalid_i,
  output logic         s_axis_tready_o,
  input  logic [127:0] s_axis_tdata_i,
  input  logic [15:0]  s_axis_tkeep_i,
  input  logic         s_axis_tlast_i,
  output logic         m_axis_tvalid_o,
  input  logic         m_axis_tready_i,
  output logic [7:0]   m_axis_tdata_o,
  output logic         m_axis_tkeep_o,
  output logic         m_axis_tlast_o,
  output logic         busy,
  output logic [7:0]   drop_cnt
);

  localparam logic LsbFirst = (LSB_FIRST != 0);

  aes_blk_t    mem_q [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  aes_blk_t    rdBlk;
  logic [15:0] keepPos;
  logic [3:0]  selPos;
  logic        selFinal;
  logic [3:0]  selByte;
  logic        accept;
  logic        store;
  logic        beat;
  logic        popFinal;

  assign rdBlk    = mem_q[rd_ptr_q];
  assign accept   = s_axis_tvalid_i && s_axis_tready_o;
  assign store    = accept && (s_axis_tkeep_i != 16'h0000);
  assign beat     = m_axis_tvalid_o && m_axis_tready_i;
  assign popFinal = beat && selFinal;
  assign selByte  = pos_to_byte(selPos, LsbFirst);

  // Reorder the read entry's keep mask into transmit order so the scan is always lowest-first.
  always_comb begin
    keepPos = 16'h0000;
    for (int p = 0; p < BLK_BYTES; p++) begin
      keepPos[p] = rdBlk.keep[pos_to_byte(4'(p), LsbFirst)];
    end
  end

  keep_scan u_keep_scan (
    .keep_i     (keepPos),
    .idx_i      (idx_q),
    .nxt_o      (selPos),
    .is_final_o (selFinal)
  );

  // Handshake and byte outputs come from registered state only; reset forces them quiet.
  always_comb begin
    s_axis_tready_o = en && !rst && (count_q != 2'd2);
    m_axis_tvalid_o = en && !rst && (count_q != 2'd0);
    m_axis_tdata_o  = 8'h00;
    m_axis_tlast_o  = 1'b0;
    if (m_axis_tvalid_o) begin
      m_axis_tdata_o = rdBlk.data[{selByte, 3'b000} +: 8];
      m_axis_tlast_o = rdBlk.last && selFinal;
    end
  end

  assign m_axis_tkeep_o = 1'b1;
  assign busy           = (count_q != 2'd0);
  assign drop_cnt       = drop_cnt_q;

  // Next-state for pointers, occupancy, byte index and the drop counter; disable flushes everything but the drop count.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    idx_d      = idx_q;
    drop_cnt_d = drop_cnt_q;
    if (!en) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
      idx_d    = 4'd0;
    end else begin
      if (store) begin
        wr_ptr_d = ~wr_ptr_q;
      end
      if (accept && (s_axis_tkeep_i == 16'h0000) && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
      if (popFinal) begin
        rd_ptr_d = ~rd_ptr_q;
        idx_d    = 4'd0;
      end else if (beat) begin
        idx_d = selPos + 4'd1;
      end
      count_d = count_q + {1'b0, store} - {1'b0, popFinal};
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      idx_q      <= 4'd0;
      drop_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Block storage; contents are only meaningful while counted as occupied, so no reset is needed.
  always_ff @(posedge clk) begin
    if (store) begin
      mem_q[wr_ptr_q] <= '{data: s_axis_tdata_i, keep: s_axis_tkeep_i, last: s_axis_tlast_i};
    end
  end

endmodule
